// File: rtl/router_pkg.sv
// Shared constants for the router output FIFO.
// ROUTER_FIFO_TRISTATE_EN selects an all-Z idle bus value instead of all-zero.
package router_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int DATA_WIDTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;

`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic IDLE_BIT = 1'bz;
`else
    localparam logic IDLE_BIT = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] IDLE = {DATA_WIDTH{IDLE_BIT}};

    // Payload length field of a header byte
    localparam int LEN_MSB = DATA_WIDTH - 1;
    localparam int LEN_LSB = 2;

endpackage

// File: rtl/router_fifo_mem.sv
// DEPTH x WIDTH register file: one write port, one registered read port.
module router_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never cleared; flushes only move the pointers
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read data is held until the next accepted read
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router with packet-boundary idle tracking.
// Build option: ROUTER_FIFO_TRISTATE_EN (idle bus value is all-Z).
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH      = router_pkg::FIFO_DEPTH,
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = DATA_WIDTH - 1;

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt_q, cnt_eff;
    logic                  rd_vld_q;   // rdata was loaded at the last edge
    logic                  out_idle;
    logic [DATA_WIDTH:0]   rdata;      // {header flag, byte}
    logic                  wr_acc, rd_acc;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc = write_enb && !full;
    assign rd_acc = read_enb && !empty;

    router_fifo_mem #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH + 1)) u_mem (
        .clk   (clk),
        .we    (wr_acc && !soft_reset),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({lfd_state, data_in}),
        .re    (rd_acc && !soft_reset),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // The byte read last edge only becomes visible now, so fold its effect
    // on the packet counter in here; cnt_eff is the up-to-date count.
    always_comb begin
        cnt_eff = cnt_q;
        if (rd_vld_q) begin
            if (rdata[DATA_WIDTH])
                cnt_eff = CNT_W'(rdata[DATA_WIDTH-1:LEN_LSB]) + CNT_W'(1);
            else if (cnt_q != '0)
                cnt_eff = cnt_q - CNT_W'(1);
        end
    end

    // Pointers, counter and idle flag; flush wins over read and write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
            out_idle <= 1'b1;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
            out_idle <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            rd_vld_q <= rd_acc;
            cnt_q    <= cnt_eff;
            if (rd_acc)
                out_idle <= 1'b0;
            else if (cnt_eff == '0)
                out_idle <= 1'b1;
        end
    end

    assign data_out = out_idle ? {DATA_WIDTH{IDLE_BIT}} : rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

    logic       clk = 1'b0;
    logic       reset, soft_reset, write_enb, lfd_state, read_enb;
    logic [7:0] data_in;
    wire  [7:0] data_out;
    logic       full, empty;
    logic [7:0] e;
    int         n_cmp = 0;
    int         n_fail = 0;

`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [7:0] EXP_IDLE = 8'bzzzz_zzzz;
`else
    localparam logic [7:0] EXP_IDLE = 8'h00;
`endif

    router_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic h);
        write_enb = 1'b1; data_in = d; lfd_state = h;
        step();
        write_enb = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        read_enb = 1'b1;
        step();
        read_enb = 1'b0;
        chk(tag, data_out, exp);
    endtask

    initial begin
        reset = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
        lfd_state = 1'b0; read_enb = 1'b0; data_in = 8'h00;
        #2;
        chk("rst_dout", data_out, EXP_IDLE);
        chk("rst_empty", {7'd0, empty}, 8'd1);
        chk("rst_full", {7'd0, full}, 8'd0);
        step();
        reset = 1'b1;
        step();

        // basic packet: header 0C (len 3) + 3 payload + parity
        wr(8'h0C, 1'b1);
        chk("p1_empty_after_wr", {7'd0, empty}, 8'd0);
        wr(8'hA1, 1'b0); wr(8'hA2, 1'b0); wr(8'hA3, 1'b0); wr(8'h5F, 1'b0);
        rd("p1_rd0", 8'h0C);
        rd("p1_rd1", 8'hA1);
        rd("p1_rd2", 8'hA2);
        rd("p1_rd3", 8'hA3);
        rd("p1_rd4", 8'h5F);
        chk("p1_empty_end", {7'd0, empty}, 8'd1);
        step();
        chk("p1_idle", data_out, EXP_IDLE);

        // fill to full: header 38 (len 14) + 15 bytes
        wr(8'h38, 1'b1);
        for (int i = 1; i < 16; i++) wr(8'(i), 1'b0);
        chk("fill_full", {7'd0, full}, 8'd1);
        wr(8'hEE, 1'b0);
        chk("drop_full", {7'd0, full}, 8'd1);
        // simultaneous read+write while full: only the read lands
        write_enb = 1'b1; data_in = 8'hEE; read_enb = 1'b1;
        step();
        write_enb = 1'b0; read_enb = 1'b0;
        chk("simfull_dout", data_out, 8'h38);
        chk("simfull_full", {7'd0, full}, 8'd0);
        for (int i = 1; i < 16; i++) begin
            e = 8'(i);
            rd("drain", e);
        end
        chk("drain_empty", {7'd0, empty}, 8'd1);
        step();
        chk("drain_idle", data_out, EXP_IDLE);

        // simultaneous read+write while empty: only the write lands
        write_enb = 1'b1; data_in = 8'h77; read_enb = 1'b1;
        step();
        write_enb = 1'b0; read_enb = 1'b0;
        chk("simempty_empty", {7'd0, empty}, 8'd0);
        chk("simempty_idle", data_out, EXP_IDLE);
        rd("malformed_rd", 8'h77);
        step();
        chk("malformed_idle", data_out, EXP_IDLE);

        // soft reset mid-packet
        wr(8'h10, 1'b1); wr(8'hB1, 1'b0); wr(8'hB2, 1'b0);
        rd("sr_rd0", 8'h10);
        rd("sr_rd1", 8'hB1);
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        chk("sr_empty", {7'd0, empty}, 8'd1);
        chk("sr_idle", data_out, EXP_IDLE);
        wr(8'h04, 1'b1); wr(8'hC1, 1'b0); wr(8'hC2, 1'b0);
        rd("sr_new0", 8'h04);
        rd("sr_new1", 8'hC1);
        rd("sr_new2", 8'hC2);
        step();
        chk("sr_new_idle", data_out, EXP_IDLE);

        // 24 write/read pairs, pointers wrap
        write_enb = 1'b1; data_in = 8'h58; lfd_state = 1'b1;
        step();
        lfd_state = 1'b0;
        for (int i = 0; i < 23; i++) begin
            data_in = 8'h80 + 8'(i); read_enb = 1'b1;
            step();
            e = (i == 0) ? 8'h58 : 8'h80 + 8'(i - 1);
            chk("wrap_data", data_out, e);
            chk("wrap_full", {7'd0, full}, 8'd0);
            chk("wrap_empty", {7'd0, empty}, 8'd0);
        end
        write_enb = 1'b0;
        step();
        read_enb = 1'b0;
        chk("wrap_last", data_out, 8'h96);
        chk("wrap_empty_end", {7'd0, empty}, 8'd1);
        step();
        chk("wrap_idle", data_out, EXP_IDLE);

        // async reset in the middle of a read
        wr(8'h08, 1'b1); wr(8'hD1, 1'b0); wr(8'hD2, 1'b0); wr(8'hD3, 1'b0);
        rd("ar_rd0", 8'h08);
        rd("ar_rd1", 8'hD1);
        read_enb = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("ar_dout", data_out, EXP_IDLE);
        chk("ar_empty", {7'd0, empty}, 8'd1);
        chk("ar_full", {7'd0, full}, 8'd0);
        read_enb = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("ar_after_empty", {7'd0, empty}, 8'd1);
        chk("ar_after_idle", data_out, EXP_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
